// File: rtl/dp_ram_arb_pkg.sv
// dp_ram_arb_pkg: shared types and sizes for the dp_ram arbiter.
// Holds the sequencer state enum and the RAM geometry.
package dp_ram_arb_pkg;

    localparam int DP_RAM_ADDR_W = 4;
    localparam int DP_RAM_DATA_W = 8;
    localparam int DP_RAM_DEPTH  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        ACK   = 2'd3
    } state_e;

endpackage

// File: rtl/dp_ram_arb_rr2.sv
// dp_ram_arb_rr2: combinational two-way grant.
// DP_RAM_ARB_RR_EN selects round-robin; otherwise port 0 has priority.
module dp_ram_arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

`ifdef DP_RAM_ARB_RR_EN
    // A tie goes to the port that did not win last time.
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end
`else
    logic unused_last;
    assign unused_last = last;

    // Port 0 always wins a tie.
    always_comb begin
        gnt = 2'b00;
        if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/dp_ram_arb.sv
// dp_ram_arb: two-port request arbiter and sequencer for dp_ram.
// Build option: DP_RAM_ARB_RR_EN selects round-robin over fixed priority.
module dp_ram_arb
    import dp_ram_arb_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [DP_RAM_ADDR_W-1:0] addr0,
    input  logic [DP_RAM_ADDR_W-1:0] addr1,
    input  logic [DP_RAM_DATA_W-1:0] wdata0,
    input  logic [DP_RAM_DATA_W-1:0] wdata1,
    output logic                     ack0,
    output logic                     ack1,
    output logic                     err0,
    output logic                     err1,
    output logic [DP_RAM_DATA_W-1:0] rdata0,
    output logic [DP_RAM_DATA_W-1:0] rdata1,
    output logic                     busy,
    output logic                     ram_w_en,
    output logic [DP_RAM_ADDR_W-1:0] ram_w_addr,
    output logic [DP_RAM_DATA_W-1:0] ram_w_data,
    output logic [DP_RAM_ADDR_W-1:0] ram_r_addr,
    input  logic [DP_RAM_DATA_W-1:0] ram_r_data
);

    state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic id_q, id_d;
    logic bad_q, bad_d;
    logic ack0_q, ack0_d, ack1_q, ack1_d;
    logic err0_q, err0_d, err1_q, err1_d;
    logic [DP_RAM_DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DP_RAM_DATA_W-1:0] rdata1_q, rdata1_d;
    logic busy_q, busy_d;
    logic w_en_q, w_en_d;
    logic [DP_RAM_ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [DP_RAM_DATA_W-1:0] w_data_q, w_data_d;
    logic [DP_RAM_ADDR_W-1:0] r_addr_q, r_addr_d;

    logic [1:0] gnt;
    logic       last_q;
    logic                     sel_we;
    logic [DP_RAM_ADDR_W-1:0] sel_addr;
    logic [DP_RAM_DATA_W-1:0] sel_wdata;

    dp_ram_arb_rr2 u_rr2 (
        .req  ({req1, req0}),
        .last (last_q),
        .gnt  (gnt)
    );

`ifdef DP_RAM_ARB_RR_EN
    logic last_d;

    // Remember the most recent grantee; reset favours port 0.
    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && gnt != 2'b00) begin
            last_d = gnt[1];
        end
    end

    // Last-grant pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign last_q = 1'b1;
`endif

    assign sel_we    = gnt[1] ? we1    : we0;
    assign sel_addr  = gnt[1] ? addr1  : addr0;
    assign sel_wdata = gnt[1] ? wdata1 : wdata0;

    // Next state, RAM controls and completion outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        id_d     = id_q;
        bad_d    = bad_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        w_en_d   = 1'b0;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        r_addr_d = r_addr_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt != 2'b00) begin
                    id_d  = gnt[1];
                    bad_d = sel_addr[3];
                    if (sel_addr[3]) begin
                        state_d = ACK;
                    end else if (sel_we) begin
                        state_d  = WRITE;
                        w_en_d   = 1'b1;
                        w_addr_d = sel_addr;
                        w_data_d = sel_wdata;
                    end else begin
                        state_d  = READ;
                        r_addr_d = sel_addr;
                        cnt_d    = 3'(RD_LAT - 1);
                    end
                end
            end
            WRITE: begin
                state_d = ACK;
            end
            READ: begin
                if (cnt_q == 3'd0) begin
                    state_d = ACK;
                    if (id_q) begin
                        rdata1_d = ram_r_data;
                    end else begin
                        rdata0_d = ram_r_data;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d == ACK) begin
            ack0_d = ~id_d;
            ack1_d = id_d;
            err0_d = ~id_d & bad_d;
            err1_d = id_d & bad_d;
        end
        busy_d = (state_d != IDLE);
    end

    // State, sequencing and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            id_q     <= 1'b0;
            bad_q    <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            busy_q   <= 1'b0;
            w_en_q   <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
            r_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            bad_q    <= bad_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            busy_q   <= busy_d;
            w_en_q   <= w_en_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            r_addr_q <= r_addr_d;
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign err0       = err0_q;
    assign err1       = err1_q;
    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;
    assign busy       = busy_q;
    assign ram_w_en   = w_en_q;
    assign ram_w_addr = w_addr_q;
    assign ram_w_data = w_data_q;
    assign ram_r_addr = r_addr_q;

endmodule
